// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: request, issue, hazard-query and register-file write port bundle
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;
    logic [ADDR_W-1:0] qry_ra;
    logic [ADDR_W-1:0] qry_rb;
    logic              haz_a;
    logic              haz_b;
    logic [ADDR_W-1:0] Rw;
    logic [DATA_W-1:0] busW;
    logic              RegWr;
    logic              wb_orphan;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, qry_ra, qry_rb,
        input  alu_ready, lsu_ready, iss_ready, haz_a, haz_b,
        input  Rw, busW, RegWr, wb_orphan
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, qry_ra, qry_rb,
        output alu_ready, lsu_ready, iss_ready, haz_a, haz_b,
        output Rw, busW, RegWr, wb_orphan
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU and tracks busy destinations; define WB_RR_EN for round-robin arbitration, otherwise LSU has fixed priority
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                WrClk,
    input logic                Rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic              grant_alu, grant_lsu, grant, wr_nz, iss_ok;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_data;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;
    logic              regwr_q, regwr_d;
    logic              orphan_q, orphan_d;

`ifdef WB_RR_EN
    logic last_lsu_q, last_lsu_d;
    assign grant_alu  = Rst_n && bus.alu_valid && (!bus.lsu_valid || last_lsu_q);
    assign grant_lsu  = Rst_n && bus.lsu_valid && (!bus.alu_valid || !last_lsu_q);
    assign last_lsu_d = grant ? grant_lsu : last_lsu_q;
`else
    assign grant_lsu = Rst_n && bus.lsu_valid;
    assign grant_alu = Rst_n && bus.alu_valid && !bus.lsu_valid;
`endif

    assign grant    = grant_alu || grant_lsu;
    assign g_rd     = grant_lsu ? bus.lsu_rd : bus.alu_rd;
    assign g_data   = grant_lsu ? bus.lsu_data : bus.alu_data;
    assign wr_nz    = grant && (g_rd != '0);
    assign iss_ok   = Rst_n && ((bus.iss_rd == '0) || !busy_q[bus.iss_rd]);
    assign rw_d     = grant ? g_rd : rw_q;
    assign busw_d   = grant ? g_data : busw_q;
    assign regwr_d  = wr_nz;
    assign orphan_d = orphan_q || (wr_nz && !busy_q[g_rd]);

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;
    assign bus.iss_ready = iss_ok;
    assign bus.haz_a     = (bus.qry_ra != '0) && busy_q[bus.qry_ra];
    assign bus.haz_b     = (bus.qry_rb != '0) && busy_q[bus.qry_rb];
    assign bus.Rw        = rw_q;
    assign bus.busW      = busw_q;
    assign bus.RegWr     = regwr_q;
    assign bus.wb_orphan = orphan_q;

    // scoreboard next state: clear on write-back, then allocation overrides so set wins
    always_comb begin
        busy_d = busy_q;
        if (wr_nz) busy_d[g_rd] = 1'b0;
        if (bus.iss_valid && iss_ok && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge WrClk) begin
        if (!Rst_n) begin
            busy_q     <= '0;
            rw_q       <= '0;
            busw_q     <= '0;
            regwr_q    <= 1'b0;
            orphan_q   <= 1'b0;
`ifdef WB_RR_EN
            last_lsu_q <= 1'b1;
`endif
        end else begin
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
            regwr_q    <= regwr_d;
            orphan_q   <= orphan_d;
`ifdef WB_RR_EN
            last_lsu_q <= last_lsu_d;
`endif
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario bench for regfile_wb_arbiter (WB_RR_EN selects round-robin expectations)
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .WrClk(clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        bus.iss_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1111_1111;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h2222_2222;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        bus.qry_ra = 5'd5; bus.qry_rb = 5'd4;
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%b exp=0", bus.alu_ready); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready got=%b exp=0", bus.lsu_ready); end
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL rst_iss_ready got=%b exp=0", bus.iss_ready); end
        step();
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL rst_regwr got=%b exp=0", bus.RegWr); end
        checks++; if (bus.wb_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan got=%b exp=0", bus.wb_orphan); end
        checks++; if (bus.haz_a !== 1'b0 || bus.haz_b !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b%b exp=00", bus.haz_a, bus.haz_b); end
        checks++; if (bus.Rw !== 5'd0 || bus.busW !== 32'd0) begin errors++; $display("FAIL rst_port got=%0d/%h exp=0/0", bus.Rw, bus.busW); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_alu();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.qry_ra = 5'd5;
        #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL alloc5_ready got=%b exp=1", bus.iss_ready); end
        step();
        bus.iss_valid = 1'b0;
        checks++; if (bus.haz_a !== 1'b1) begin errors++; $display("FAIL haz5_set got=%b exp=1", bus.haz_a); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%b exp=1", bus.alu_ready); end
        step();
        bus.alu_valid = 1'b0;
        checks++; if (bus.RegWr !== 1'b1) begin errors++; $display("FAIL alu_regwr got=%b exp=1", bus.RegWr); end
        checks++; if (bus.Rw !== 5'd5) begin errors++; $display("FAIL alu_rw got=%0d exp=5", bus.Rw); end
        checks++; if (bus.busW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_busw got=%h exp=deadbeef", bus.busW); end
        checks++; if (bus.haz_a !== 1'b0) begin errors++; $display("FAIL haz5_clr got=%b exp=0", bus.haz_a); end
        checks++; if (bus.wb_orphan !== 1'b0) begin errors++; $display("FAIL alu_orphan got=%b exp=0", bus.wb_orphan); end
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL alu_regwr_drop got=%b exp=0", bus.RegWr); end
        checks++; if (bus.Rw !== 5'd5 || bus.busW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_hold got=%0d/%h exp=5/deadbeef", bus.Rw, bus.busW); end
    endtask

    task automatic test_contention();
        logic exp_alu;
        logic [4:0] exp_rw;
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0A03;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h0000_0B04;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_RR_EN
            exp_alu = (i % 2 == 0);
`else
            exp_alu = 1'b0;
`endif
            exp_rw = exp_alu ? 5'd3 : 5'd4;
            #1;
            checks++; if (bus.alu_ready !== exp_alu || bus.lsu_ready !== !exp_alu) begin errors++; $display("FAIL cont%0d_grant got=%b%b exp=%b%b", i, bus.alu_ready, bus.lsu_ready, exp_alu, !exp_alu); end
            step();
            checks++; if (bus.Rw !== exp_rw || bus.RegWr !== 1'b1) begin errors++; $display("FAIL cont%0d_rw got=%0d/%b exp=%0d/1", i, bus.Rw, bus.RegWr, exp_rw); end
        end
        idle();
    endtask

    task automatic test_set_clear();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.qry_ra = 5'd7;
        step();
        checks++; if (bus.haz_a !== 1'b1) begin errors++; $display("FAIL sc_busy7 got=%b exp=1", bus.haz_a); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777_7777;
        #1;
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sc_iss_blocked got=%b exp=0", bus.iss_ready); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL sc_lsu_ready got=%b exp=1", bus.lsu_ready); end
        step();
        bus.lsu_valid = 1'b0;
        checks++; if (bus.haz_a !== 1'b0) begin errors++; $display("FAIL sc_cleared got=%b exp=0", bus.haz_a); end
        checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd7) begin errors++; $display("FAIL sc_write got=%b/%0d exp=1/7", bus.RegWr, bus.Rw); end
        #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sc_iss_next got=%b exp=1", bus.iss_ready); end
        step();
        bus.iss_valid = 1'b0;
        checks++; if (bus.haz_a !== 1'b1) begin errors++; $display("FAIL sc_realloc got=%b exp=1", bus.haz_a); end
    endtask

    task automatic test_x0();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_1234;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        bus.qry_ra = 5'd7; bus.qry_rb = 5'd0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready got=%b exp=1", bus.alu_ready); end
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got=%b exp=1", bus.iss_ready); end
        step();
        idle();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL x0_regwr got=%b exp=0", bus.RegWr); end
        checks++; if (bus.Rw !== 5'd0 || bus.busW !== 32'h0000_1234) begin errors++; $display("FAIL x0_port got=%0d/%h exp=0/00001234", bus.Rw, bus.busW); end
        checks++; if (bus.haz_a !== 1'b1 || bus.haz_b !== 1'b0) begin errors++; $display("FAIL x0_busy got=%b%b exp=10", bus.haz_a, bus.haz_b); end
    endtask

    task automatic test_orphan_reset();
        do_reset();
        checks++; if (bus.wb_orphan !== 1'b0) begin errors++; $display("FAIL orph_pre got=%b exp=0", bus.wb_orphan); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h9999_0009;
        step();
        checks++; if (bus.wb_orphan !== 1'b1) begin errors++; $display("FAIL orph_set got=%b exp=1", bus.wb_orphan); end
        checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd9) begin errors++; $display("FAIL orph_write got=%b/%0d exp=1/9", bus.RegWr, bus.Rw); end
        step();
        checks++; if (bus.wb_orphan !== 1'b1 || bus.RegWr !== 1'b1) begin errors++; $display("FAIL orph_sticky got=%b/%b exp=1/1", bus.wb_orphan, bus.RegWr); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL orph_rst_ready got=%b exp=0", bus.lsu_ready); end
        step();
        checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL orph_rst_regwr got=%b exp=0", bus.RegWr); end
        checks++; if (bus.wb_orphan !== 1'b0) begin errors++; $display("FAIL orph_rst_clr got=%b exp=0", bus.wb_orphan); end
        idle();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_set_clear();
        test_x0();
        test_orphan_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
